// File: rtl/fetch_queue_stage.sv
// Decoupled fetch stage: owns the fetch PC, steers it from the branch predictor,
// and buffers returned instructions in a DEPTH-entry FIFO drained by the scoreboard.
module fetch_queue_stage #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] PC_STEP = XLEN'(4)
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       ihit,
  input  logic [XLEN-1:0]            imemload,
  output logic                       imemREN,
  output logic [XLEN-1:0]            imemaddr,
  output logic [XLEN-1:0]            bp_pc,
  input  logic                       bp_taken,
  input  logic [XLEN-1:0]            bp_target,
  input  logic                       redirect,
  input  logic [XLEN-1:0]            redirect_pc,
  input  logic                       halt,
  input  logic                       deq_ready,
  output logic                       deq_valid,
  output logic [XLEN-1:0]            deq_pc,
  output logic [XLEN-1:0]            deq_instr,
  output logic                       deq_pred,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic [1:0] {RUN, FULL, HALTED} state_t;

  state_t          state, next_state;
  logic [XLEN-1:0] fetch_pc, next_pc;
  logic [PW-1:0]   head, tail;
  logic [CW-1:0]   count_q;
  logic            enq, deq, flush;

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];
  logic [DEPTH-1:0] pred_mem;

  assign imemREN   = (state == RUN) && !redirect && !halt;
  assign imemaddr  = fetch_pc;
  assign bp_pc     = fetch_pc;
  assign enq       = imemREN && ihit;
  assign deq_valid = (count_q != '0) && (state != HALTED);
  assign deq       = deq_valid && deq_ready;
  assign flush     = halt || redirect || (state == HALTED);
  assign next_pc   = bp_taken ? bp_target : fetch_pc + PC_STEP;
  assign count     = count_q;

  assign deq_pc    = deq_valid ? pc_mem[head]    : '0;
  assign deq_instr = deq_valid ? instr_mem[head] : '0;
  assign deq_pred  = deq_valid ? pred_mem[head]  : 1'b0;

  always_comb begin
    next_state = state;
    if (halt) begin
      next_state = HALTED;
    end else begin
      case (state)
        RUN: begin
          if (!redirect && enq && !deq && count_q == FULL_COUNT - CW'(1))
            next_state = FULL;
        end
        FULL: begin
          if (redirect || (deq && !enq))
            next_state = RUN;
        end
        HALTED: next_state = HALTED;
        default: next_state = RUN;
      endcase
    end
  end

  // Halt outranks redirect, and HALTED keeps the queue empty until reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= RUN;
      fetch_pc <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count_q  <= '0;
    end else begin
      state <= next_state;
      if (flush) begin
        head    <= '0;
        tail    <= '0;
        count_q <= '0;
        if (!halt && state != HALTED)
          fetch_pc <= redirect_pc;
      end else begin
        if (enq) begin
          tail     <= tail + PW'(1);
          fetch_pc <= next_pc;
        end
        if (deq)
          head <= head + PW'(1);
        case ({enq, deq})
          2'b10:   count_q <= count_q + CW'(1);
          2'b01:   count_q <= count_q - CW'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && enq) begin
      pc_mem[tail]    <= fetch_pc;
      instr_mem[tail] <= imemload;
      pred_mem[tail]  <= bp_taken;
    end
  end

endmodule

// File: doc/fetch_queue_stage.md
Name: fetch_queue_stage

Overview:
Parametrised, decoupled fetch stage: owns the fetch PC, issues instruction-memory reads, and steers the next PC from the branch-predictor query. Each returned instruction goes into a DEPTH-entry FIFO of {pc, instr, pred} entries, and the scoreboard drains that FIFO through a valid/ready handshake. This replaces the single-slot freeze/hold scheme. Redirects from branch resolution flush the queue and restart fetch at the corrected PC.

Parameters:
XLEN, 32, PC/address/instruction width
DEPTH, 4, FIFO entries; power of two, >= 2
RESET_PC, 0, fetch PC after reset
PC_STEP, 4, sequential PC increment

Ports:
CLK  in  1  clock
RST  in  1  synchronous reset, active-high
ihit  in  1  imem response valid for current imemaddr
imemload  in  XLEN  imem read data
imemREN  out  1  imem read enable
imemaddr  out  XLEN  imem read address (= fetch PC)
bp_pc  out  XLEN  PC presented to branch predictor (= fetch PC)
bp_taken  in  1  predictor: bp_pc predicted taken (combinational on bp_pc)
bp_target  in  XLEN  predictor target for bp_pc
redirect  in  1  misprediction/jump correction
redirect_pc  in  XLEN  corrected PC
halt  in  1  stop fetching permanently until reset
deq_ready  in  1  scoreboard accepts head entry
deq_valid  out  1  head entry valid
deq_pc  out  XLEN  head PC
deq_instr  out  XLEN  head instruction
deq_pred  out  1  head predicted-taken bit
count  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset (RST high at CLK edge):
  - fetch_pc=RESET_PC, state=RUN, count=0, head/tail pointers=0.
  - Resulting outputs: deq_valid=0, deq_pc=0, deq_instr=0, deq_pred=0, imemREN=1.
- States:
  - RUN: normal fetching.
  - FULL: count==DEPTH.
  - HALTED: absorbing until RST.
- RUN transitions: to FULL when an enqueue without a dequeue reaches count==DEPTH; to HALTED on halt.
- FULL transitions: back to RUN when a dequeue occurs with no enqueue.
- imemREN = (state==RUN) && !redirect && !halt. It is combinational; there is no enqueue path in FULL.
- imemaddr=bp_pc=fetch_pc. Both are held stable until ihit, a redirect, or halt.
- Enqueue fires when imemREN && ihit:
  - Writes {fetch_pc, imemload, bp_taken} at tail; tail wraps modulo DEPTH.
  - Next fetch_pc = bp_taken ? bp_target : fetch_pc+PC_STEP (mod 2^XLEN).
- Dequeue fires when deq_valid && deq_ready; head wraps modulo DEPTH.
- deq_valid = (count!=0) && state!=HALTED.
  - When deq_valid=0, deq_pc/deq_instr/deq_pred are driven to 0 (bubble).
  - Outputs come straight from FIFO storage: zero added latency, so an entry enqueued at edge N is visible after edge N.
- Simultaneous enqueue+dequeue: count unchanged, both pointers advance. A FIFO with DEPTH entries full therefore never enqueues.
- Redirect (priority over enqueue and dequeue):
  - Next edge: count=0, head=tail=0, fetch_pc=redirect_pc, state=RUN.
  - Any ihit in the redirect cycle is discarded.
  - deq_valid is 0 in the cycle after the redirect.
  - The first post-redirect entry can appear at the earliest 1 cycle later.
- Halt (priority over redirect):
  - Next edge: state=HALTED, queue flushed, imemREN=0, deq_valid=0.
  - Only RST leaves HALTED.
- RST mid-operation overrides everything, including a pending ihit and redirect.
- Latency: ihit at edge N puts the entry on deq_* after edge N, with the next request address presented in the same cycle.

Test Plan:
- Reset, deq_ready=1, ihit every cycle, bp_taken=0 -> imemaddr 0,4,8,12; deq_pc follows 1 cycle later; count stays <=1.
- deq_ready=0, ihit every cycle, DEPTH=4 -> count 1,2,3,4; imemREN=0 at count=4, imemaddr held 0x10. Then deq_ready=1 for one cycle -> deq_pc=0, count=3, refetch 0x10.
- Full queue, 8 further enq/deq cycles -> pointers wrap; deq_pc strictly sequential 0x00..0x2C with no loss or duplication.
- bp_taken=1, bp_target=0x100 at pc 0x8 -> entry {0x8, instr, pred=1}; next imemaddr=0x100.
- Queue with 3 entries, redirect=1, redirect_pc=0x200, ihit=1 same cycle -> next cycle count=0, deq_valid=0, imemaddr=0x200; the ihit data never appears on deq_*.
- halt with redirect asserted together -> HALTED, imemREN=0, deq_valid=0 indefinitely. RST -> imemaddr=RESET_PC, imemREN=1.
